// File: rtl/next_pc_unit.sv
// Fetch-side next-PC selection with per-stage prediction records.
// Mispredictions are resolved in EX, which flushes IF/ID and ID/EX and redirects fetch.
module next_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt,
  input  logic             IF_PC_hit,
  input  logic             Pred_Jump,
  input  logic [31:0]      PC_des_out,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_jump,
  input  logic [31:0]      ex_jump_target,
  output logic [31:0]      IF_PC,
  output logic [31:0]      EX_PC,
  output logic             EX_Branch,
  output logic             Branch_Success,
  output logic [31:0]      PC_des_in,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } rec_t;

  rec_t        id_r;
  rec_t        ex_r;
  rec_t        if_rec;
  logic        actual_taken;
  logic [31:0] actual_tgt;
  logic        mispredict;
  logic [31:0] redirect_pc;

  always_comb begin
    if_rec.valid       = 1'b1;
    if_rec.pc          = IF_PC;
    if_rec.pred_taken  = IF_PC_hit & Pred_Jump;
    if_rec.pred_target = PC_des_out;
  end

  // EX resolution; everything that acts on it is gated by ex_r.valid.
  always_comb begin
    actual_taken = ex_jump | (ex_is_branch & ex_taken);
    actual_tgt   = ex_jump ? ex_jump_target : ex_target;
    mispredict   = (ex_r.pred_taken != actual_taken) |
                   (actual_taken & (ex_r.pred_target != actual_tgt));
    redirect_pc  = actual_taken ? actual_tgt : ex_r.pc + 32'd4;
  end

  assign flush          = ex_r.valid & mispredict;
  assign EX_Branch      = ex_is_branch & ex_r.valid;
  assign Branch_Success = ex_taken & EX_Branch;
  assign PC_des_in      = ex_target;
  assign EX_PC          = ex_r.pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IF_PC <= RESET_PC;
    end else if (flush) begin
      IF_PC <= redirect_pc;
    end else if (halt || stall) begin
      IF_PC <= IF_PC;
    end else if (if_rec.pred_taken) begin
      IF_PC <= if_rec.pred_target;
    end else begin
      IF_PC <= IF_PC + 32'd4;
    end
  end

  // A flush kills both younger records even while stalled or halted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_r <= '0;
      ex_r <= '0;
    end else if (flush) begin
      id_r.valid <= 1'b0;
      ex_r.valid <= 1'b0;
    end else if (halt) begin
      id_r <= id_r;
      ex_r <= ex_r;
    end else if (stall) begin
      id_r       <= id_r;
      ex_r.valid <= 1'b0;
    end else begin
      id_r <= if_rec;
      ex_r <= id_r;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (!halt) begin
      if (EX_Branch) branch_cnt  <= branch_cnt + CNT_W'(1);
      if (flush)     mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule
